sobel_window_scheduler: RTL

Sequences the Sobel stage of the image pipeline. It tracks grayscale pixels arriving from the RGB-to-gray converter and walks the frame in raster order. For each pixel it issues one read of the 3x3 neighbourhood memory, then presents a window-valid strobe and coordinates to the Sobel filter, with downstream backpressure. It also flags border pixels, which skip the memory read and produce a zero output. It sits between the multi-port window memory and the Sobel filter, replacing free-running coordinate counters.

---
 rtl/sobel_window_scheduler.sv | 174 +++++++++++++++++
 1 files changed

// File: rtl/sobel_window_scheduler.sv
// Raster-order scheduler for the Sobel stage: gates on rows already written to the
// window memory, issues one read per interior pixel, and presents windows with backpressure.
module sobel_window_scheduler #(
  parameter int DIM_W   = 16,
  parameter int MEM_LAT = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             frame_start,
  input  logic [DIM_W-1:0] height,
  input  logic [DIM_W-1:0] width,
  input  logic             gray_valid,
  input  logic             out_ready,
  output logic             rd_en,
  output logic [DIM_W-1:0] rd_h,
  output logic [DIM_W-1:0] rd_w,
  output logic             win_valid,
  output logic             win_border,
  output logic [DIM_W-1:0] out_h,
  output logic [DIM_W-1:0] out_w,
  output logic             busy,
  output logic             frame_done,
  output logic             size_err
);

  // Handshake: a window transfers on any rising clk where win_valid and out_ready are
  // both 1; while win_valid=1 and out_ready=0, out_h/out_w/win_border stay unchanged.
  typedef enum logic [2:0] {
    S_IDLE, S_WAIT_ROWS, S_ISSUE, S_WAIT_MEM, S_PRESENT, S_DONE
  } state_e;

  localparam logic [DIM_W-1:0] ONE      = {{(DIM_W-1){1'b0}}, 1'b1};
  localparam logic [DIM_W:0]   TWO      = {{(DIM_W-1){1'b0}}, 2'd2};
  localparam logic [2:0]       LAT_LAST = 3'(MEM_LAT - 1);

  state_e           state_q;
  logic [DIM_W-1:0] h_q, w_q, r_q, c_q, wcol_q, wrows_q;
  logic [2:0]       lat_q;
  logic             rd_en_q, win_valid_q, win_border_q, busy_q, frame_done_q, size_err_q;

  logic [DIM_W-1:0] h_last, w_last;
  logic [DIM_W:0]   need_rows, cap_rows;
  logic             rows_ready, last_col, last_pix, cur_border, next_border;

  function automatic logic is_border(input logic [DIM_W-1:0] r, c, r_last, c_last);
    return (r == '0) || (r == r_last) || (c == '0) || (c == c_last);
  endfunction

  always_comb begin
    h_last      = h_q - ONE;
    w_last      = w_q - ONE;
    need_rows   = {1'b0, r_q} + TWO;
    cap_rows    = (need_rows < {1'b0, h_q}) ? need_rows : {1'b0, h_q};
    rows_ready  = ({1'b0, wrows_q} >= cap_rows);
    last_col    = (c_q == w_last);
    last_pix    = last_col && (r_q == h_last);
    cur_border  = is_border(r_q, c_q, h_last, w_last);
    next_border = is_border(r_q, c_q + ONE, h_last, w_last);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= S_IDLE;
      h_q          <= '0;
      w_q          <= '0;
      r_q          <= '0;
      c_q          <= '0;
      wcol_q       <= '0;
      wrows_q      <= '0;
      lat_q        <= '0;
      rd_en_q      <= 1'b0;
      win_valid_q  <= 1'b0;
      win_border_q <= 1'b0;
      busy_q       <= 1'b0;
      frame_done_q <= 1'b0;
      size_err_q   <= 1'b0;
    end else begin
      frame_done_q <= 1'b0;
      // Write tracking saturates once all H rows have landed in window memory.
      if (state_q != S_IDLE && gray_valid && wrows_q < h_q) begin
        if (wcol_q == w_last) begin
          wcol_q  <= '0;
          wrows_q <= wrows_q + ONE;
        end else begin
          wcol_q <= wcol_q + ONE;
        end
      end
      case (state_q)
        S_IDLE: begin
          if (frame_start) begin
            h_q        <= height;
            w_q        <= width;
            r_q        <= '0;
            c_q        <= '0;
            wcol_q     <= '0;
            wrows_q    <= '0;
            busy_q     <= 1'b1;
            size_err_q <= (height == '0) || (width == '0);
            if (height == '0 || width == '0) begin
              state_q      <= S_DONE;
              frame_done_q <= 1'b1;
            end else begin
              state_q <= S_WAIT_ROWS;
            end
          end
        end
        S_WAIT_ROWS: begin
          if (rows_ready) begin
            state_q <= S_ISSUE;
            rd_en_q <= !cur_border;
          end
        end
        S_ISSUE: begin
          rd_en_q <= 1'b0;
          if (cur_border) begin
            state_q      <= S_PRESENT;
            win_valid_q  <= 1'b1;
            win_border_q <= 1'b1;
          end else begin
            state_q <= S_WAIT_MEM;
            lat_q   <= '0;
          end
        end
        S_WAIT_MEM: begin
          if (lat_q == LAT_LAST) begin
            state_q      <= S_PRESENT;
            win_valid_q  <= 1'b1;
            win_border_q <= 1'b0;
          end else begin
            lat_q <= lat_q + 3'd1;
          end
        end
        S_PRESENT: begin
          if (out_ready) begin
            win_valid_q  <= 1'b0;
            win_border_q <= 1'b0;
            if (last_col) begin
              c_q <= '0;
              r_q <= r_q + ONE;
            end else begin
              c_q <= c_q + ONE;
            end
            if (last_pix) begin
              state_q      <= S_DONE;
              frame_done_q <= 1'b1;
            end else if (last_col) begin
              state_q <= S_WAIT_ROWS;
            end else begin
              state_q <= S_ISSUE;
              rd_en_q <= !next_border;
            end
          end
        end
        S_DONE: begin
          state_q <= S_IDLE;
          busy_q  <= 1'b0;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign rd_en      = rd_en_q;
  assign rd_h       = r_q;
  assign rd_w       = c_q;
  assign win_valid  = win_valid_q;
  assign win_border = win_border_q;
  assign out_h      = r_q;
  assign out_w      = c_q;
  assign busy       = busy_q;
  assign frame_done = frame_done_q;
  assign size_err   = size_err_q;

endmodule
